pc_control: RTL and testbench

Program-counter controller for the pipelined ARM core, replacing the single-cycle PC-select logic. It detects PC-writing instructions in decode, tracks them down a parametrised-depth pipeline, and squashes not-taken conditional ones in execute. It stalls fetch and flushes decode while a PC write is in flight, and owns the PC register, loading the writeback result when the write retires. It sits between the decode stage, the hazard unit and the instruction-memory address port.

---
 rtl/pc_pkg.sv | 12 +
 rtl/pc_pending_pipe.sv | 47 ++++
 rtl/pc_control.sv | 76 +++++++
 tb/tb_pc_control.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared defaults and limits for the program-counter controller.
package pc_pkg;

  localparam int PC_REG_DEFAULT   = 15;
  localparam int RESET_PC_DEFAULT = 0;
  localparam int INC_DEFAULT      = 4;
  localparam int DEPTH_DEFAULT    = 3;
  localparam int PEND_MAX         = 8;

  typedef logic [PEND_MAX-1:0] pend_max_t;

endpackage

// File: rtl/pc_pending_pipe.sv
// Tracks in-flight PC writes from execute to writeback and derives the
// fetch stall, decode flush and PC-source control.
module pc_pending_pipe
  import pc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcs,
  input  logic             valid_d,
  input  logic             stall_ext,
  input  logic             cond_ex_e,
  output logic [DEPTH-1:0] pend,
  output logic             pc_src_w,
  output logic             stall_f,
  output logic             flush_d
);

  logic [DEPTH-1:0] pend_d;
  logic [DEPTH-1:0] pend_q;

  always_comb begin
    pend_d    = '0;
    // a stalled decode enters execute as a bubble
    pend_d[0] = pcs & valid_d & ~stall_ext;
    // not-taken conditionals die leaving execute
    pend_d[1] = pend_q[0] & cond_ex_e;
    for (int k = 2; k < DEPTH; k++) begin
      pend_d[k] = pend_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend     = pend_q;
  assign pc_src_w = pend_q[DEPTH-1];
  assign stall_f  = (pcs & valid_d) | (|pend_q[DEPTH-2:0]);
  assign flush_d  = stall_f | pc_src_w;

endmodule

// File: rtl/pc_control.sv
// Program-counter controller: PC-write detect in decode, the PC register
// and its incrementer, with the in-flight tracking in pc_pending_pipe.
module pc_control
  import pc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int RA_W     = 4,
  parameter int PC_REG   = PC_REG_DEFAULT,
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int INC      = INC_DEFAULT,
  parameter int RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  Rd,
  input  logic             RegW,
  input  logic             Branch,
  input  logic             ValidD,
  input  logic             StallExt,
  input  logic             CondExE,
  input  logic [WIDTH-1:0] ResultW,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlusInc,
  output logic             PCS,
  output logic             PCSrcW,
  output logic             StallF,
  output logic             FlushD,
  output logic [DEPTH-1:0] Pending
);

  localparam logic [WIDTH-1:0] INC_V   = WIDTH'(INC);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_PC);
  localparam logic [RA_W-1:0]  PC_IDX  = RA_W'(PC_REG);

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  assign PCS       = ((Rd == PC_IDX) & RegW) | Branch;
  assign PCPlusInc = pc_q + INC_V;

  pc_pending_pipe #(
    .DEPTH (DEPTH)
  ) u_pend (
    .clk       (clk),
    .reset     (reset),
    .pcs       (PCS),
    .valid_d   (ValidD),
    .stall_ext (StallExt),
    .cond_ex_e (CondExE),
    .pend      (Pending),
    .pc_src_w  (PCSrcW),
    .stall_f   (StallF),
    .flush_d   (FlushD)
  );

  // a retiring PC write overrides any stall
  always_comb begin
    pc_d = pc_q;
    if (PCSrcW) begin
      pc_d = ResultW;
    end else if (!(StallF | StallExt)) begin
      pc_d = PCPlusInc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_V;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_pc_control.sv
// Randomised and directed bench for pc_control against a queue-based model.
module tb_pc_control;
  import pc_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 3;
  localparam int INC   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [3:0]       Rd;
  logic             RegW, Branch, ValidD, StallExt, CondExE;
  logic [W-1:0]     ResultW;
  logic [W-1:0]     PC, PCPlusInc;
  logic             PCS, PCSrcW, StallF, FlushD;
  logic [DEPTH-1:0] Pending;

  logic [3:0] rd8;
  logic       regw8, branch8, validd8, stallext8, condexe8;
  logic [7:0] resultw8, pc8, pcinc8;
  logic       pcs8, pcsrc8, stallf8, flushd8;
  logic [2:0] pend8;

  pc_control #(.WIDTH(W), .DEPTH(DEPTH), .INC(INC)) dut (
    .clk(clk), .reset(reset), .Rd(Rd), .RegW(RegW), .Branch(Branch),
    .ValidD(ValidD), .StallExt(StallExt), .CondExE(CondExE), .ResultW(ResultW),
    .PC(PC), .PCPlusInc(PCPlusInc), .PCS(PCS), .PCSrcW(PCSrcW),
    .StallF(StallF), .FlushD(FlushD), .Pending(Pending)
  );

  pc_control #(.WIDTH(8), .DEPTH(3), .INC(4), .RESET_PC(252)) dut8 (
    .clk(clk), .reset(reset), .Rd(rd8), .RegW(regw8), .Branch(branch8),
    .ValidD(validd8), .StallExt(stallext8), .CondExE(condexe8), .ResultW(resultw8),
    .PC(pc8), .PCPlusInc(pcinc8), .PCS(pcs8), .PCSrcW(pcsrc8),
    .StallF(stallf8), .FlushD(flushd8), .Pending(pend8)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: each in-flight PC write is an entry holding the stage it occupies.
  int       q[$];
  logic [W-1:0] mpc;
  logic     prev_flush;

  function automatic logic m_pcs();
    return ((Rd == 4'd15) && RegW) || Branch;
  endfunction

  function automatic logic [DEPTH-1:0] m_pend();
    logic [DEPTH-1:0] r = '0;
    foreach (q[i]) r[q[i]] = 1'b1;
    return r;
  endfunction

  function automatic logic m_src();
    foreach (q[i]) if (q[i] == DEPTH-1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_stallf();
    if (m_pcs() && ValidD) return 1'b1;
    foreach (q[i]) if (q[i] < DEPTH-1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    int       nq[$];
    logic [W-1:0] npc;
    logic     src, stf;
    @(negedge clk);
    src = m_src();
    stf = m_stallf();
    check("pc",      PC,        mpc);
    check("pcinc",   PCPlusInc, mpc + INC);
    check("pcs",     PCS,       m_pcs());
    check("pcsrcw",  PCSrcW,    src);
    check("stallf",  StallF,    stf);
    check("flushd",  FlushD,    stf | src);
    check("pending", Pending,   m_pend());
    prev_flush = stf | src;
    if (reset) begin
      npc = '0;
    end else begin
      if (src) npc = ResultW;
      else if (stf || StallExt) npc = mpc;
      else npc = mpc + INC;
      foreach (q[i]) begin
        if (q[i] == 0 && !CondExE) continue;
        if (q[i] + 1 < DEPTH) nq.push_back(q[i] + 1);
      end
      if (m_pcs() && ValidD && !StallExt) nq.push_back(0);
    end
    @(posedge clk);
    q   = nq;
    mpc = npc;
    #1;
  endtask

  task automatic idle();
    Rd = 4'd0; RegW = 1'b0; Branch = 1'b0; ValidD = 1'b0;
    StallExt = 1'b0; CondExE = 1'b1;
  endtask

  logic [W-1:0] p;

  initial begin
    rd8 = 4'd0; regw8 = 1'b0; branch8 = 1'b0; validd8 = 1'b1;
    stallext8 = 1'b0; condexe8 = 1'b0; resultw8 = 8'h00;
    idle();
    ResultW = '0;
    reset = 1'b1;
    prev_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    mpc = '0;
    reset = 1'b0;

    check("rst_pc",      PC,      32'd0);
    check("rst_pending", Pending, 3'd0);
    check("rst_stallf",  StallF,  1'b0);
    check("rst_flushd",  FlushD,  1'b0);
    check("rst_pcsrcw",  PCSrcW,  1'b0);
    check("rst_pc8",     pc8,     8'hFC);

    // idle sequential fetch
    ValidD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("idle_pc", PC, 32'(4 * i));
      step();
      if (i == 0) check("wrap_pc8", pc8, 8'h00);
    end

    // taken branch
    Branch = 1'b1; ValidD = 1'b1;
    step();
    idle();
    step();
    step();
    ResultW = 32'h100;
    step();
    check("br_pc", PC, 32'h100);
    ResultW = $urandom;
    step();
    check("br_pc_inc", PC, 32'h104);

    // not-taken write to the PC register
    Rd = 4'd15; RegW = 1'b1; ValidD = 1'b1;
    step();
    check("nt_pend0", Pending, 3'b001);
    idle(); CondExE = 1'b0;
    step();
    check("nt_pend1", Pending, 3'b000);
    CondExE = 1'b1;
    p = PC;
    check("nt_stallf", StallF, 1'b0);
    step();
    check("nt_resume", PC, p + 4);

    // branch blocked by external stall, then released
    Branch = 1'b1; ValidD = 1'b1; StallExt = 1'b1;
    p = PC;
    step();
    check("se_pend", Pending, 3'b000);
    check("se_pc",   PC,      p);
    StallExt = 1'b0;
    step();
    check("se_go", Pending, 3'b001);
    idle();
    step();
    step();
    ResultW = 32'h200;
    step();
    check("se_pc_load", PC, 32'h200);

    // reset during an in-flight branch
    Branch = 1'b1; ValidD = 1'b1;
    step();
    idle();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_pending", Pending, 3'b000);
    check("mr_pc",      PC,      32'd0);
    for (int i = 0; i < 4; i++) begin
      check("mr_pcsrcw", PCSrcW, 1'b0);
      step();
    end

    // randomised traffic; decode is emptied after any flush
    for (int n = 0; n < 600; n++) begin
      Rd       = 4'($urandom_range(0, 15));
      RegW     = 1'($urandom_range(0, 3) == 0);
      Branch   = 1'($urandom_range(0, 5) == 0);
      ValidD   = 1'($urandom_range(0, 3) != 0) & ~prev_flush;
      StallExt = 1'($urandom_range(0, 7) == 0);
      CondExE  = 1'($urandom_range(0, 2) != 0);
      ResultW  = $urandom;
      reset    = 1'($urandom_range(0, 99) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
